seq_magnitude_comparator: RTL

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/cmp_pkg.sv | 13 +
 rtl/digit_comparator.sv | 19 +
 rtl/seq_magnitude_comparator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
package cmp_pkg;

    localparam int unsigned CMP_WIDTH = 16;
    localparam int unsigned CMP_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

endpackage

// File: rtl/digit_comparator.sv
// Combinational compare of one DIGIT-bit slice.
module digit_comparator #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    // Unsigned relation of the two digits.
    always_comb begin
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial magnitude comparator: walks the captured operands from the most
// significant digit down and stops at the first digit that differs.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH,
    parameter int unsigned DIGIT = CMP_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;

    logic [31:0]      base;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_lt, dig_gt, dig_eq;

    // Select the current digit; in signed mode the sign bits are flipped on the
    // top digit so that an unsigned digit compare orders two's-complement values.
    always_comb begin
        base  = 32'(idx_q) * DIGIT;
        dig_a = a_q[base +: DIGIT];
        dig_b = b_q[base +: DIGIT];
        if (mode_q && (idx_q == IW'(NDIG - 1))) begin
            dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
            dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
        end
    end

    digit_comparator #(
        .DIGIT(DIGIT)
    ) u_digit_comparator (
        .a  (dig_a),
        .b  (dig_b),
        .lt (dig_lt),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    // Next-state, operand capture and result flag logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = signed_mode;
                    idx_d   = IW'(NDIG - 1);
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (dig_eq) begin
                    if (idx_q == '0) begin
                        eq_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else begin
                    lt_d    = dig_lt;
                    gt_d    = dig_gt;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign lt   = lt_q;
    assign gt   = gt_q;
    assign eq   = eq_q;

endmodule
